// File: rtl/wallace_pkg.sv
// -----------------------------------------------------------------------------
// wallace_pkg
// Purpose : compile-time helpers that size the carry-save reduction tree.
//   needed_stages(n)         number of 3:2 levels to reduce n partials to 2
//   level_count(n, k)        partial count remaining after k levels
//   pipe_depth(s, reg_every) register stages for s levels (output always reg'd)
//   level_is_registered(...) true for internal levels that end in a register
// Ports   : none (package)
// -----------------------------------------------------------------------------
package wallace_pkg;

    function automatic int needed_stages(input int n);
        int cnt;
        int s;
        cnt = n;
        s   = 0;
        while (cnt > 2) begin
            cnt = (cnt / 3) * 2 + cnt % 3;
            s++;
        end
        return s;
    endfunction

    function automatic int level_count(input int n, input int k);
        int cnt;
        cnt = n;
        for (int i = 0; i < k; i++) begin
            if (cnt > 2) cnt = (cnt / 3) * 2 + cnt % 3;
        end
        return cnt;
    endfunction

    function automatic int pipe_depth(input int s, input int reg_every);
        if (s == 0) return 1;
        return (s + reg_every - 1) / reg_every;
    endfunction

    // The last level always feeds the output register, so it is never
    // counted as an internal register boundary here.
    function automatic bit level_is_registered(input int k, input int s,
                                               input int reg_every);
        return (k < s - 1) && (((k + 1) % reg_every) == 0);
    endfunction

endpackage

// File: rtl/wallace_tree_pipe_if.sv
// -----------------------------------------------------------------------------
// wallace_tree_pipe_if
// Purpose : bundles the beat input and result output handshakes.
//   in_valid/in_ready   : beat of PARTIAL_COUNT partials (+ in_acc_clr sideband)
//   out_valid/out_ready : redundant result pair sum/carry
// Handshake: a transfer happens on a rising clk edge where valid && ready.
//   A producer holds valid and its data stable until that edge; ready may
//   depend combinationally on the other side, valid never depends on ready.
// Modports: slave = the reduction block, master = the driver/consumer side.
// -----------------------------------------------------------------------------
interface wallace_tree_pipe_if #(
    parameter int PARTIAL_COUNT = 6,
    parameter int BW            = 22
);
    logic          in_valid;
    logic          in_ready;
    logic [BW-1:0] in_data [PARTIAL_COUNT];
    logic          in_acc_clr;
    logic          out_valid;
    logic          out_ready;
    logic [BW-1:0] sum;
    logic [BW-1:0] carry;

    modport master (
        output in_valid, in_data, in_acc_clr, out_ready,
        input  in_ready, out_valid, sum, carry
    );

    modport slave (
        input  in_valid, in_data, in_acc_clr, out_ready,
        output in_ready, out_valid, sum, carry
    );
endinterface

// File: rtl/csa32.sv
// -----------------------------------------------------------------------------
// csa32
// Purpose : 3:2 carry-save compressor with the carry already shifted into
//           its weight position; the carry-out of the top bit is dropped.
// Ports   : i_x, i_y, i_z  BW-bit addends
//           o_s            bitwise sum
//           o_c            majority carries shifted left by one
// -----------------------------------------------------------------------------
module csa32 #(
    parameter int BW = 22
) (
    input  logic [BW-1:0] i_x,
    input  logic [BW-1:0] i_y,
    input  logic [BW-1:0] i_z,
    output logic [BW-1:0] o_s,
    output logic [BW-1:0] o_c
);
    logic [BW-1:0] w_maj;

    assign w_maj = (i_x & i_y) | (i_y & i_z) | (i_x & i_z);
    assign o_s   = i_x ^ i_y ^ i_z;
    assign o_c   = w_maj << 1;
endmodule

// File: rtl/wallace_tree_pipe.sv
// -----------------------------------------------------------------------------
// wallace_tree_pipe
// Purpose : pipelined carry-save reduction of PARTIAL_COUNT partials to a
//           redundant sum/carry pair, with an optional carry-save accumulator.
// Ports   : clk   rising-edge clock
//           rst   synchronous active-high reset
//           bus   wallace_tree_pipe_if.slave (beat in, result out)
// All stages move together on advance = !out_valid || out_ready; in_ready is
// that same signal, so a held result freezes the whole pipe.
// -----------------------------------------------------------------------------
module wallace_tree_pipe
    import wallace_pkg::*;
#(
    parameter int PARTIAL_COUNT = 6,
    parameter int BW            = 22,
    parameter int REG_EVERY     = 1,
    parameter int ACC_EN        = 0
) (
    input logic                clk,
    input logic                rst,
    wallace_tree_pipe_if.slave bus
);
    localparam int P = PARTIAL_COUNT;
    localparam int S = needed_stages(PARTIAL_COUNT);

    logic          w_advance;
    // w_lvl[k] is the input of level k; w_lvl[S] is the final reduced set.
    logic [BW-1:0] w_lvl [S+1][P];
    logic          w_v   [S+1];
    logic          w_clr [S+1];

    logic          r_out_valid;
    logic [BW-1:0] r_sum;
    logic [BW-1:0] r_carry;
    logic [BW-1:0] w_fs;
    logic [BW-1:0] w_fc;
    logic [BW-1:0] w_nxt_s;
    logic [BW-1:0] w_nxt_c;

    assign w_advance     = !r_out_valid || bus.out_ready;
    assign bus.in_ready  = w_advance;
    assign bus.out_valid = r_out_valid;
    assign bus.sum       = r_sum;
    assign bus.carry     = r_carry;

    for (genvar i = 0; i < P; i++) begin : g_in
        assign w_lvl[0][i] = bus.in_data[i];
    end
    assign w_v[0]   = bus.in_valid;
    assign w_clr[0] = bus.in_acc_clr;

    for (genvar k = 0; k < S; k++) begin : g_level
        localparam int N = level_count(P, k);
        localparam int G = N / 3;
        localparam int R = N - 3 * G;
        logic [BW-1:0] w_out [P];

        // Triples compress in index order; outputs land as s0,c0,s1,c1,...
        for (genvar g = 0; g < G; g++) begin : g_csa
            csa32 #(.BW(BW)) u_csa (
                .i_x(w_lvl[k][3*g]),
                .i_y(w_lvl[k][3*g+1]),
                .i_z(w_lvl[k][3*g+2]),
                .o_s(w_out[2*g]),
                .o_c(w_out[2*g+1])
            );
        end
        for (genvar j = 0; j < R; j++) begin : g_left
            assign w_out[2*G+j] = w_lvl[k][3*G+j];
        end
        for (genvar j = 2 * G + R; j < P; j++) begin : g_zero
            assign w_out[j] = '0;
        end

        if (level_is_registered(k, S, REG_EVERY)) begin : g_reg
            logic [BW-1:0] r_d [P];
            logic          r_v;

            always_ff @(posedge clk) begin
                if (rst)            r_v <= 1'b0;
                else if (w_advance) r_v <= w_v[k];
            end
            // Data needs no reset: it is only observed behind r_v.
            always_ff @(posedge clk) begin
                if (w_advance) begin
                    for (int i = 0; i < P; i++) r_d[i] <= w_out[i];
                end
            end

            if (ACC_EN != 0) begin : g_clr
                logic r_clr;
                always_ff @(posedge clk) begin
                    if (rst)            r_clr <= 1'b0;
                    else if (w_advance) r_clr <= w_clr[k];
                end
                assign w_clr[k+1] = r_clr;
            end else begin : g_noclr
                assign w_clr[k+1] = w_clr[k];
            end

            for (genvar i = 0; i < P; i++) begin : g_q
                assign w_lvl[k+1][i] = r_d[i];
            end
            assign w_v[k+1] = r_v;
        end else begin : g_wire
            for (genvar i = 0; i < P; i++) begin : g_q
                assign w_lvl[k+1][i] = w_out[i];
            end
            assign w_v[k+1]   = w_v[k];
            assign w_clr[k+1] = w_clr[k];
        end
    end

    assign w_fs = w_lvl[S][0];
    if (level_count(P, S) >= 2) begin : g_pair
        assign w_fc = w_lvl[S][1];
    end else begin : g_single
        assign w_fc = '0;
    end

    if (ACC_EN != 0) begin : g_acc
        // 4:2 fold of the tree pair into the running pair (or zero on clr).
        logic [BW-1:0] w_as;
        logic [BW-1:0] w_ac;
        logic [BW-1:0] w_s1;
        logic [BW-1:0] w_c1;

        assign w_as = w_clr[S] ? '0 : r_sum;
        assign w_ac = w_clr[S] ? '0 : r_carry;

        csa32 #(.BW(BW)) u_acc0 (
            .i_x(w_fs), .i_y(w_fc), .i_z(w_as), .o_s(w_s1), .o_c(w_c1)
        );
        csa32 #(.BW(BW)) u_acc1 (
            .i_x(w_s1), .i_y(w_c1), .i_z(w_ac), .o_s(w_nxt_s), .o_c(w_nxt_c)
        );
    end else begin : g_noacc
        assign w_nxt_s = w_fs;
        assign w_nxt_c = w_fc;
    end

    // Output stage doubles as the accumulator; bubbles leave it untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_sum       <= '0;
            r_carry     <= '0;
        end else if (w_advance) begin
            r_out_valid <= w_v[S];
            if (w_v[S]) begin
                r_sum   <= w_nxt_s;
                r_carry <= w_nxt_c;
            end
        end
    end
endmodule

// File: tb/tb_wallace_tree_pipe.sv
// -----------------------------------------------------------------------------
// tb_wallace_tree_pipe
// Four instances share one stimulus bus; sel routes the handshake to one DUT
// at a time (others see in_valid=0, out_ready=1):
//   0: P=6 REG_EVERY=1        1: P=6 REG_EVERY=1 ACC_EN=1
//   2: P=2                    3: P=6 REG_EVERY=2
// Reference: arithmetic sum of the partials (mod 2^BW), running total for
// the accumulating instance, exact operands for the P=2 passthrough.
// -----------------------------------------------------------------------------
module tb_wallace_tree_pipe;
    localparam int BW = 22;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // ---------------- shared stimulus ----------------
    logic          tb_valid;
    logic          tb_clr;
    logic          tb_ready;
    logic [BW-1:0] tb_data [6];
    int            sel;

    logic          obs_in_ready;
    logic          obs_out_valid;
    logic [BW-1:0] obs_sum;
    logic [BW-1:0] obs_carry;

    wallace_tree_pipe_if #(.PARTIAL_COUNT(6), .BW(BW)) if_a   ();
    wallace_tree_pipe_if #(.PARTIAL_COUNT(6), .BW(BW)) if_acc ();
    wallace_tree_pipe_if #(.PARTIAL_COUNT(2), .BW(BW)) if_p2  ();
    wallace_tree_pipe_if #(.PARTIAL_COUNT(6), .BW(BW)) if_r2  ();

    assign if_a.in_valid    = tb_valid && (sel == 0);
    assign if_acc.in_valid  = tb_valid && (sel == 1);
    assign if_p2.in_valid   = tb_valid && (sel == 2);
    assign if_r2.in_valid   = tb_valid && (sel == 3);
    assign if_a.out_ready   = (sel == 0) ? tb_ready : 1'b1;
    assign if_acc.out_ready = (sel == 1) ? tb_ready : 1'b1;
    assign if_p2.out_ready  = (sel == 2) ? tb_ready : 1'b1;
    assign if_r2.out_ready  = (sel == 3) ? tb_ready : 1'b1;
    assign if_a.in_acc_clr   = tb_clr;
    assign if_acc.in_acc_clr = tb_clr;
    assign if_p2.in_acc_clr  = tb_clr;
    assign if_r2.in_acc_clr  = tb_clr;

    for (genvar i = 0; i < 6; i++) begin : g_data
        assign if_a.in_data[i]   = tb_data[i];
        assign if_acc.in_data[i] = tb_data[i];
        assign if_r2.in_data[i]  = tb_data[i];
    end
    assign if_p2.in_data[0] = tb_data[0];
    assign if_p2.in_data[1] = tb_data[1];

    always_comb begin
        obs_in_ready  = if_a.in_ready;
        obs_out_valid = if_a.out_valid;
        obs_sum       = if_a.sum;
        obs_carry     = if_a.carry;
        case (sel)
            1: begin
                obs_in_ready = if_acc.in_ready; obs_out_valid = if_acc.out_valid;
                obs_sum = if_acc.sum; obs_carry = if_acc.carry;
            end
            2: begin
                obs_in_ready = if_p2.in_ready; obs_out_valid = if_p2.out_valid;
                obs_sum = if_p2.sum; obs_carry = if_p2.carry;
            end
            3: begin
                obs_in_ready = if_r2.in_ready; obs_out_valid = if_r2.out_valid;
                obs_sum = if_r2.sum; obs_carry = if_r2.carry;
            end
            default: ;
        endcase
    end

    wallace_tree_pipe #(.PARTIAL_COUNT(6), .BW(BW), .REG_EVERY(1), .ACC_EN(0))
        u_dut_a   (.clk(clk), .rst(rst), .bus(if_a));
    wallace_tree_pipe #(.PARTIAL_COUNT(6), .BW(BW), .REG_EVERY(1), .ACC_EN(1))
        u_dut_acc (.clk(clk), .rst(rst), .bus(if_acc));
    wallace_tree_pipe #(.PARTIAL_COUNT(2), .BW(BW), .REG_EVERY(1), .ACC_EN(0))
        u_dut_p2  (.clk(clk), .rst(rst), .bus(if_p2));
    wallace_tree_pipe #(.PARTIAL_COUNT(6), .BW(BW), .REG_EVERY(2), .ACC_EN(0))
        u_dut_r2  (.clk(clk), .rst(rst), .bus(if_r2));

    // ---------------- scoreboard ----------------
    logic [BW-1:0] exp_q   [$];
    logic [BW-1:0] exp_s_q [$];
    logic [BW-1:0] exp_c_q [$];
    int            acc_cyc_q [$];
    logic [BW-1:0] acc_model;
    int            lat_tab [4] = '{3, 3, 1, 2};
    int            p_tab   [4] = '{6, 6, 2, 6};
    int            checks   = 0;
    int            failures = 0;
    int            cyc      = 0;
    int            n_out    = 0;
    int            n_acc;
    int            out_mark;
    bit            acc_flag;
    bit            chk_lat;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [BW-1:0] beat_total(input int p);
        logic [BW-1:0] t;
        t = '0;
        for (int i = 0; i < p; i++) t = t + tb_data[i];
        return t;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic rand_data();
        for (int i = 0; i < 6; i++) tb_data[i] = BW'($urandom);
    endtask

    task automatic ramp_data();
        for (int i = 0; i < 6; i++) tb_data[i] = BW'(i + 1);
    endtask

    // One clock: sample at negedge (accept + result check), then step past posedge.
    task automatic tick();
        logic [BW-1:0] bt;
        logic [BW-1:0] got;
        @(negedge clk);
        cyc++;
        acc_flag = 1'b0;
        if (!rst && tb_valid && obs_in_ready) begin
            acc_flag = 1'b1;
            bt = beat_total(p_tab[sel]);
            if (sel == 1) begin
                acc_model = tb_clr ? bt : acc_model + bt;
                exp_q.push_back(acc_model);
            end else begin
                exp_q.push_back(bt);
            end
            exp_s_q.push_back(tb_data[0]);
            exp_c_q.push_back(tb_data[1]);
            acc_cyc_q.push_back(cyc);
        end
        got = obs_sum + obs_carry;
        if (!rst && obs_out_valid) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                failures++;
                $error("FAIL spurious_out_valid got=1 expected=0 sel=%0d", sel);
            end
            if (exp_q.size() != 0) begin
                if (tb_ready) begin
                    n_out++;
                    chk("total", 32'(got), 32'(exp_q.pop_front()));
                    if (sel == 2) begin
                        chk("p2_sum", 32'(obs_sum), 32'(exp_s_q[0]));
                        chk("p2_carry", 32'(obs_carry), 32'(exp_c_q[0]));
                    end
                    if (chk_lat) chk("latency", 32'(cyc - acc_cyc_q[0]), 32'(lat_tab[sel]));
                    void'(exp_s_q.pop_front());
                    void'(exp_c_q.pop_front());
                    void'(acc_cyc_q.pop_front());
                end else begin
                    chk("stall_hold", 32'(got), 32'(exp_q[0]));
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic clr);
        int n;
        tb_valid = 1'b1;
        tb_clr   = clr;
        n = 0;
        do begin
            tick();
            n++;
        end while (!acc_flag && n < 20);
        chk("send_accept", 32'(acc_flag), 32'd1);
        tb_valid = 1'b0;
    endtask

    task automatic stream(input int beats, input bit rand_clr);
        tb_valid = 1'b1;
        for (int i = 0; i < beats; i++) begin
            rand_data();
            tb_clr = rand_clr ? 1'($urandom_range(0, 3) == 0) : 1'b0;
            tick();
            chk("stream_accept", 32'(acc_flag), 32'd1);
        end
        tb_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        tb_valid = 1'b0;
        tb_ready = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            tick();
            n++;
        end
        chk("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        tb_valid = 1'b0;
        tb_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(obs_out_valid), 32'd0);
        chk("rst_sum", 32'(obs_sum), 32'd0);
        chk("rst_carry", 32'(obs_carry), 32'd0);
        chk("rst_in_ready", 32'(obs_in_ready), 32'd1);
        rst = 1'b0;
        exp_q.delete();
        exp_s_q.delete();
        exp_c_q.delete();
        acc_cyc_q.delete();
        acc_model = '0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst = 1'b1; tb_valid = 1'b0; tb_clr = 1'b0; tb_ready = 1'b1; sel = 0;
        acc_model = '0; chk_lat = 1'b1;
        for (int i = 0; i < 6; i++) tb_data[i] = '0;

        // --- instance 0: basic tree, L=3 ---
        do_reset();
        ramp_data();
        send(1'b0);
        drain();
        chk("ramp_total_21", 32'(obs_sum + obs_carry), 32'd21);
        for (int i = 0; i < 6; i++) tb_data[i] = 22'h3FFFFF;
        send(1'b0);
        drain();
        chk("all_ones_total", 32'(BW'(obs_sum + obs_carry)), 32'h3FFFFA);
        stream(100, 1'b0);
        drain();

        // back-pressure: out_ready low for 5 cycles while feeding
        chk_lat  = 1'b0;
        out_mark = n_out;
        tb_ready = 1'b0;
        n_acc    = 0;
        rand_data();
        tb_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (acc_flag) begin n_acc++; rand_data(); end
        end
        chk("bp_accepted", 32'(n_acc), 32'd3);
        chk("bp_in_ready_low", 32'(obs_in_ready), 32'd0);
        chk("bp_out_valid_held", 32'(obs_out_valid), 32'd1);
        tb_ready = 1'b1;
        for (int i = 0; i < 20 && n_acc < 6; i++) begin
            tick();
            if (acc_flag) begin n_acc++; rand_data(); end
        end
        tb_valid = 1'b0;
        drain();
        chk("bp_results", 32'(n_out - out_mark), 32'd6);
        chk_lat = 1'b1;

        // reset with two beats in flight
        rand_data();
        tb_valid = 1'b1;
        tick();
        rand_data();
        tick();
        out_mark = n_out;
        do_reset();
        for (int i = 0; i < 6; i++) tick();
        chk("reset_no_out", 32'(n_out - out_mark), 32'd0);
        rand_data();
        send(1'b0);
        drain();

        // --- instance 1: accumulator ---
        sel = 1;
        do_reset();
        for (int b = 0; b < 4; b++) begin
            ramp_data();
            send((b == 0) || (b == 3));
            drain();
            for (int i = 0; i < 3; i++) tick();
            chk("acc_bubble_hold", 32'(BW'(obs_sum + obs_carry)), 32'(acc_model));
        end
        chk("acc_final_21", 32'(BW'(obs_sum + obs_carry)), 32'd21);
        stream(30, 1'b1);
        drain();

        // --- instance 2: P=2 passthrough, L=1 ---
        sel = 2;
        do_reset();
        stream(20, 1'b0);
        drain();

        // --- instance 3: P=6, REG_EVERY=2, L=2 ---
        sel = 3;
        do_reset();
        ramp_data();
        send(1'b0);
        drain();
        chk("r2_ramp_total_21", 32'(obs_sum + obs_carry), 32'd21);
        stream(20, 1'b0);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/wallace_tree_pipe.md
# wallace_tree_pipe

Pipelined, parametrised carry-save reduction tree. It compresses `PARTIAL_COUNT` partial products of `BW` bits into a redundant sum/carry pair, with pipeline registers placed every `REG_EVERY` CSA levels and a valid/ready handshake that supports back-pressure. An optional carry-save accumulator (`ACC_EN`) folds successive results into a running redundant total. It sits between the partial-product generators and the Kulisch accumulator / final CPA in the TensorCore datapath.

## Interface
- `PARTIAL_COUNT`, 6, number of input partials (≥1)
- `BW`, 22, width of each partial and of both outputs
- `REG_EVERY`, 1, CSA levels per pipeline stage (≥1)
- `ACC_EN`, 0, 1 = outputs are a running carry-save accumulation
- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `in_valid`  in  1  input beat valid
- `in_ready`  out  1  block can accept a beat
- `in_data`  in  `[BW-1:0] x PARTIAL_COUNT`  partial products, unpacked array
- `in_acc_clr`  in  1  sideband travelling with the beat; ignored when `ACC_EN=0`
- `out_valid`  out  1  result valid
- `out_ready`  in  1  consumer accepts result
- `sum`  out  BW  redundant sum
- `carry`  out  BW  redundant carry, already weight-aligned

## Operation
- Level count `S = needed_stages(PARTIAL_COUNT)`. Iterate `n -> (n/3)*2 + n%3` while `n > 2`.
- Pipeline depth `L = max(1, ceil(S/REG_EVERY))`. The output is always registered.
- Each level groups partials in index order: `(0,1,2)`, `(3,4,5)`, …
  - Each triple feeds one `csa32`.
  - Output order per level: s0, c0, s1, c1, …, then leftovers in original order.
- `csa32`: `s = x^y^z`; `c = ((x&y)|(y&z)|(x&z)) << 1`. Bit BW of the carry is discarded.
- Invariant: `(sum + carry) mod 2^BW == Σ in_data mod 2^BW` for every beat.
- Final reduced count 1: `sum = p0`, `carry = 0`. Count 2: `sum = p0`, `carry = p1`, passed through unchanged.
- `ACC_EN=1`: the last pipeline stage holds the accumulator pair `(acc_s, acc_c)`.
  - On each beat entering it: `(acc_s, acc_c) <= 4:2 compress(tree_s, tree_c, A_s, A_c)`, built from two `csa32` levels.
  - `(A_s, A_c)` is `(0, 0)` if that beat's `in_acc_clr` is 1, else the current `(acc_s, acc_c)`.
  - `sum`/`carry` present the accumulator.
- `ACC_EN=0`: `in_acc_clr` is unused and carries no pipeline flop.
- Per stage there is a valid bit and data registers, plus the `acc_clr` bit when `ACC_EN=1`.

## Timing
- Global stall: `advance = !out_valid || out_ready`.
  - All stages shift only when `advance = 1`.
  - `in_ready = advance`, combinational from `out_ready` and `out_valid`.
- A beat is accepted when `in_valid && in_ready`. Its result appears with `out_valid = 1` exactly `L` cycles later when there is no stall.
- Bubbles (`in_valid = 0` while advancing) propagate as invalid stages.
- In accumulate mode, bubbles never update `acc`.
- `out_valid` held with `out_ready = 0`: `sum`, `carry`, `acc` and all stages hold; no beat is lost or duplicated.
- Throughput is 1 beat/cycle when `out_ready` is held high.
- Reset values: `out_valid = 0`, `sum = 0`, `carry = 0`, all stage valids 0, `acc_s = acc_c = 0`.
  - `in_ready = 1` in the cycle after reset deasserts. `in_ready` is a function of `out_valid`, so it reads 1 while `rst` is held.
- Reset mid-operation discards every in-flight beat and clears the accumulator. No `out_valid` appears for discarded beats.
- `PARTIAL_COUNT ≤ 2` (`S = 0`): `L = 1`, a register-only passthrough.

## Structure
- Package `wallace_pkg` holds:
  - `needed_stages(n)`
  - `level_count(n, k)`: partial count after k levels
  - `pipe_depth(S, REG_EVERY)`
- Sub-module `csa32` (parameter `BW`): the shifted-carry 3:2 compressor, instantiated via generate loops over level and group.
- Level boundaries with registers: levels `k` where `(k+1) % REG_EVERY == 0`, plus the final level.

## Test plan
- `P=6`, `BW=22`, `REG_EVERY=1` (`S=3`, `L=3`), `in = 1..6` -> `out_valid` 3 cycles after accept, `sum + carry = 21`.
- All six inputs `0x3FFFFF` -> `(sum + carry) mod 2^22 = 0x3FFFFA`. A back-to-back stream of 100 random beats checks the invariant on each output, in order, one per cycle.
- `out_ready = 0` for 5 cycles while feeding 6 beats -> `in_ready` drops after 3 beats are held (`L=3`). After release, 6 results arrive in order with no loss and no duplicates.
- `ACC_EN=1`, each beat `in = 1..6`, clr pattern 1,0,0,1 -> accumulated `sum + carry` = 21, 42, 63, 21. Bubbles in between leave the value unchanged.
- Assert `rst` for 1 cycle with 2 beats in flight -> no `out_valid` for them, `sum = carry = 0`. The next accepted beat's result is unaffected.
- Degenerate/regs: `P=2` -> `L=1`, `sum = in[0]`, `carry = in[1]`. `P=6`, `REG_EVERY=2` -> `L=2`, same results as the first scenario.
